// File: rtl/snn_output_spike_classifier.sv
// Purpose: counts output-neuron spikes over a window of SNN timesteps and registers a class decision.
// Latency: result_valid pulses in the second cycle after the final sample strobe (2 cycles after start if window_len==0).
// Backpressure: none; start is ignored while busy, abort cancels a running window without a result.
//
// Ports:
//   system_clock, reset  - rising-edge clock, asynchronous active-low reset
//   start, abort         - one-cycle window begin / cancel requests
//   sample_en            - one-cycle timestep strobe qualifying output_spikes
//   output_spikes[1:0]   - bit0 class-0 neuron, bit1 class-1 neuron
//   window_len           - strobes per window, latched at start
//   busy                 - window in progress (COUNT or DECIDE)
//   result_valid         - one-cycle pulse when winner/count0/count1 are final
//   winner               - 00 none, 01 class 0, 10 class 1, 11 tie
//   count0, count1       - saturating per-class spike counts, held after completion
module snn_output_spike_classifier #(
  parameter int CNT_BITS = 8,
  parameter int WIN_BITS = 8
) (
  input  logic                system_clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                sample_en,
  input  logic [1:0]          output_spikes,
  input  logic [WIN_BITS-1:0] window_len,
  output logic                busy,
  output logic                result_valid,
  output logic [1:0]          winner,
  output logic [CNT_BITS-1:0] count0,
  output logic [CNT_BITS-1:0] count1
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_DECIDE = 2'd2
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  state_t              state_q;
  logic [WIN_BITS-1:0] remaining_q;
  logic                result_valid_q;
  logic [1:0]          winner_q;
  logic [CNT_BITS-1:0] count0_q;
  logic [CNT_BITS-1:0] count1_q;

  // Saturating increment: a full counter stays at all-ones instead of wrapping.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c,
                                                  input logic             hit);
    if (hit && (c != CNT_MAX)) begin
      return c + CNT_BITS'(1);
    end
    return c;
  endfunction

  function automatic logic [1:0] decide(input logic [CNT_BITS-1:0] c0,
                                        input logic [CNT_BITS-1:0] c1);
    if ((c0 == '0) && (c1 == '0)) begin
      return 2'b00;
    end else if (c0 > c1) begin
      return 2'b01;
    end else if (c1 > c0) begin
      return 2'b10;
    end
    return 2'b11;
  endfunction

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      remaining_q    <= '0;
      result_valid_q <= 1'b0;
      winner_q       <= 2'b00;
      count0_q       <= '0;
      count1_q       <= '0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // start outranks abort here; a sample in the start cycle is not counted.
          if (start) begin
            count0_q    <= '0;
            count1_q    <= '0;
            remaining_q <= window_len;
            state_q     <= (window_len == '0) ? S_DECIDE : S_COUNT;
          end
        end
        S_COUNT: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (sample_en) begin
            count0_q    <= sat_inc(count0_q, output_spikes[0]);
            count1_q    <= sat_inc(count1_q, output_spikes[1]);
            remaining_q <= remaining_q - WIN_BITS'(1);
            if (remaining_q == WIN_BITS'(1)) begin
              state_q <= S_DECIDE;
            end
          end
        end
        S_DECIDE: begin
          // Counts are final here, so the decision uses the registered values.
          if (abort) begin
            state_q <= S_IDLE;
          end else begin
            winner_q       <= decide(count0_q, count1_q);
            result_valid_q <= 1'b1;
            state_q        <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result_valid = result_valid_q;
  assign winner       = winner_q;
  assign count0       = count0_q;
  assign count1       = count1_q;

endmodule

// File: tb/tb_snn_output_spike_classifier.sv
// Purpose: self-checking bench for snn_output_spike_classifier (8-bit and 2-bit counter instances).
// Latency: expected results are queued with the cycle they are due and compared when result_valid fires.
// Backpressure: n/a; every wait for a result is bounded by a cycle budget.
module tb_snn_output_spike_classifier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       sample_en = 1'b0;
  logic [1:0] spk = 2'b00;
  logic [7:0] wlen = 8'd0;

  logic       busy, rv;
  logic [1:0] win;
  logic [7:0] c0, c1;
  logic       busy_s, rv_s;
  logic [1:0] win_s;
  logic [1:0] c0_s, c1_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] win;
    int         at;
  } exp_t;

  typedef struct {
    logic [7:0]  wlen;
    logic [15:0] spikes;
    int          gap;
    logic [7:0]  c0;
    logic [7:0]  c1;
    logic [1:0]  win;
  } vec_t;

  exp_t sb[$];
  exp_t got;
  vec_t vecs[5];
  bit   rv_seen;

  snn_output_spike_classifier #(.CNT_BITS(8), .WIN_BITS(8)) dut (
    .system_clock (clk),
    .reset        (rst_n),
    .start        (start),
    .abort        (abort),
    .sample_en    (sample_en),
    .output_spikes(spk),
    .window_len   (wlen),
    .busy         (busy),
    .result_valid (rv),
    .winner       (win),
    .count0       (c0),
    .count1       (c1)
  );

  snn_output_spike_classifier #(.CNT_BITS(2), .WIN_BITS(8)) dut_s (
    .system_clock (clk),
    .reset        (rst_n),
    .start        (start),
    .abort        (abort),
    .sample_en    (sample_en),
    .output_spikes(spk),
    .window_len   (wlen),
    .busy         (busy_s),
    .result_valid (rv_s),
    .winner       (win_s),
    .count0       (c0_s),
    .count1       (c1_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every result_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && rv) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_result: result_valid=1 at cycle %0d, expected 0", cyc);
      end else begin
        got = sb.pop_front();
        check("sb_winner", int'(win), int'(got.win));
        check("sb_count0", int'(c0), int'(got.c0));
        check("sb_count1", int'(c1), int'(got.c1));
        check("sb_latency_cycle", cyc, got.at);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] wl, input logic ab, input logic se,
                          input logic [1:0] sp);
    start     = 1'b1;
    wlen      = wl;
    abort     = ab;
    sample_en = se;
    spk       = sp;
    tick();
    start     = 1'b0;
    abort     = 1'b0;
    sample_en = 1'b0;
    spk       = 2'b00;
  endtask

  task automatic strobe(input logic [1:0] sp, input bit push, input logic [7:0] e0,
                        input logic [7:0] e1, input logic [1:0] ew);
    sample_en = 1'b1;
    spk       = sp;
    if (push) sb.push_back('{e0, e1, ew, cyc + 2});
    tick();
    sample_en = 1'b0;
    spk       = 2'b00;
  endtask

  task automatic wait_sb(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d results still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    do_start(v.wlen, 1'b0, 1'b0, 2'b00);
    check({name, "_busy_after_start"}, int'(busy), 1);
    check({name, "_count0_cleared"}, int'(c0), 0);
    check({name, "_count1_cleared"}, int'(c1), 0);
    for (int i = 0; i < int'(v.wlen); i++) begin
      strobe(v.spikes[2*i +: 2], (i == int'(v.wlen) - 1), v.c0, v.c1, v.win);
      if (i != int'(v.wlen) - 1) repeat (v.gap) tick();
    end
    wait_sb(name);
    check({name, "_rv_cleared"}, int'(rv), 0);
    check({name, "_busy_done"}, int'(busy), 0);
    check({name, "_count0_hold"}, int'(c0), int'(v.c0));
    check({name, "_winner_hold"}, int'(win), int'(v.win));
  endtask

  initial begin
    vecs[0] = '{8'd5, {6'b0, 2'b11, 2'b00, 2'b10, 2'b01, 2'b01}, 2, 8'd3, 8'd2, 2'b01};
    vecs[1] = '{8'd3, {10'b0, 2'b00, 2'b00, 2'b11}, 0, 8'd1, 8'd1, 2'b11};
    vecs[2] = '{8'd2, 16'h0000, 0, 8'd0, 8'd0, 2'b00};
    vecs[3] = '{8'd4, {8'b0, 2'b00, 2'b11, 2'b10, 2'b10}, 1, 8'd1, 8'd3, 2'b10};
    vecs[4] = '{8'd6, 16'h0555, 0, 8'd6, 8'd0, 2'b01};

    // Reset state
    tick();
    tick();
    check("reset_busy", int'(busy), 0);
    check("reset_rv", int'(rv), 0);
    check("reset_winner", int'(win), 0);
    check("reset_count0", int'(c0), 0);
    check("reset_count1", int'(c1), 0);
    rst_n = 1'b1;
    tick();

    // Table-driven windows
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Last vector drove six class-0 spikes into the 2-bit instance
    check("sat_count0", int'(c0_s), 3);
    check("sat_count1", int'(c1_s), 0);
    check("sat_winner", int'(win_s), 1);

    // Asynchronous reset in the middle of a 10-strobe window
    do_start(8'd10, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) strobe(2'b11, 1'b0, 8'd0, 8'd0, 2'b00);
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_winner", int'(win), 0);
    check("arst_count0", int'(c0), 0);
    check("arst_count1", int'(c1), 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_vec(vecs[0], "post_reset");

    // Abort after 3 strobes, with a sample in the abort cycle
    do_start(8'd8, 1'b0, 1'b0, 2'b00);
    strobe(2'b01, 1'b0, 8'd0, 8'd0, 2'b00);
    strobe(2'b11, 1'b0, 8'd0, 8'd0, 2'b00);
    strobe(2'b01, 1'b0, 8'd0, 8'd0, 2'b00);
    abort     = 1'b1;
    sample_en = 1'b1;
    spk       = 2'b11;
    tick();
    abort     = 1'b0;
    sample_en = 1'b0;
    spk       = 2'b00;
    check("abort_busy", int'(busy), 0);
    check("abort_count0", int'(c0), 3);
    check("abort_count1", int'(c1), 1);
    rv_seen = 1'b0;
    repeat (6) begin
      if (rv) rv_seen = 1'b1;
      tick();
    end
    check("abort_no_result", int'(rv_seen), 0);
    check("abort_winner_kept", int'(win), 1);

    // abort alone in IDLE does nothing
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_busy", int'(busy), 0);
    check("idle_abort_count0", int'(c0), 3);

    // Sample in the start cycle is not counted
    do_start(8'd2, 1'b0, 1'b1, 2'b11);
    strobe(2'b01, 1'b0, 8'd0, 8'd0, 2'b00);
    strobe(2'b01, 1'b1, 8'd2, 8'd0, 2'b01);
    wait_sb("start_sample");

    // Zero-length window together with abort: start wins, result 2 cycles later
    start = 1'b1;
    abort = 1'b1;
    wlen  = 8'd0;
    sb.push_back('{8'd0, 8'd0, 2'b00, cyc + 2});
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("zero_win_busy", int'(busy), 1);
    wait_sb("zero_win");
    check("zero_win_winner", int'(win), 0);

    // Start while busy is ignored; window_len change mid-window has no effect
    do_start(8'd4, 1'b0, 1'b0, 2'b00);
    strobe(2'b10, 1'b0, 8'd0, 8'd0, 2'b00);
    start = 1'b1;
    wlen  = 8'd1;
    tick();
    start = 1'b0;
    check("busy_start_busy", int'(busy), 1);
    check("busy_start_count1", int'(c1), 1);
    strobe(2'b10, 1'b0, 8'd0, 8'd0, 2'b00);
    tick();
    strobe(2'b10, 1'b0, 8'd0, 8'd0, 2'b00);
    strobe(2'b01, 1'b1, 8'd1, 8'd3, 2'b10);
    wait_sb("busy_start");
    check("busy_start_idle", int'(busy), 0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
